// File: rtl/carousel_pkg.sv
// carousel_pkg: state encoding shared by the carousel scheduler and its lane slots.
package carousel_pkg;

    localparam int CAROUSEL_STATE_W = 2;

    // Batch phases. Encoding 2'b11 is never produced; the FSM treats it as a fault.
    typedef enum logic [CAROUSEL_STATE_W-1:0] {
        FILL   = 2'b00,
        ROTATE = 2'b01,
        DRAIN  = 2'b10
    } carousel_state_t;

endpackage

// File: rtl/carousel_scheduler_if.sv
// carousel_scheduler_if: per-lane handshakes plus datapath strobes between the
// scheduler (master) and the producers/consumers/datapath around it (slave).
interface carousel_scheduler_if #(
    parameter int NUM_LANES = 3
) ();

    logic [NUM_LANES-1:0] data_in_valid;
    logic [NUM_LANES-1:0] data_in_ready;
    logic [NUM_LANES-1:0] data_out_valid;
    logic [NUM_LANES-1:0] data_out_ready;
    logic [NUM_LANES-1:0] lane_load;
    logic                 rotate_en;

    modport master (
        input  data_in_valid,
        input  data_out_ready,
        output data_in_ready,
        output data_out_valid,
        output lane_load,
        output rotate_en
    );

    modport slave (
        output data_in_valid,
        output data_out_ready,
        input  data_in_ready,
        input  data_out_valid,
        input  lane_load,
        input  rotate_en
    );

endinterface

// File: rtl/carousel_lane_slot.sv
// carousel_lane_slot: occupancy flag and handshake decode for one carousel lane.
// Ready/valid are derived only from the registered full flag and the batch state,
// never from the partner's same-direction signal.
module carousel_lane_slot
    import carousel_pkg::*;
(
    input  logic            clk,
    input  logic            rst,        // asynchronous, active low
    input  carousel_state_t state,
    input  logic            in_en,      // low until the first edge after reset release
    input  logic            clr,        // fault recovery: drop occupancy
    input  logic            in_valid,
    input  logic            out_ready,
    output logic            in_ready,
    output logic            out_valid,
    output logic            lane_load,
    output logic            full
);

    logic full_q;
    logic full_d;

    assign in_ready  = (state == FILL) && in_en && !full_q;
    assign lane_load = in_valid && in_ready;
    assign out_valid = (state == DRAIN) && full_q;
    assign full      = full_q;

    // Occupancy: set by an accepted load, cleared by an accepted drain.
    always_comb begin
        full_d = full_q;
        if (clr) begin
            full_d = 1'b0;
        end else if (lane_load) begin
            full_d = 1'b1;
        end else if (out_valid && out_ready) begin
            full_d = 1'b0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/carousel_scheduler.sv
// carousel_scheduler: batch sequencer for an N-lane rotating register buffer.
// Cycle: fill every lane, rotate cfg_rotations steps, drain every lane, repeat.
// Optional feature macro: CAROUSEL_SCHED_FLUSH_EN adds a flush input that lets a
// partially filled carousel start its batch early.
module carousel_scheduler
    import carousel_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int ROT_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,            // asynchronous, active low
    input  logic [ROT_W-1:0]            cfg_rotations,
`ifdef CAROUSEL_SCHED_FLUSH_EN
    input  logic                        flush,
`endif
    carousel_scheduler_if.master        bus,
    output logic                        busy,
    output logic [CAROUSEL_STATE_W-1:0] state_o
);

    carousel_state_t      state_q;
    carousel_state_t      state_d;
    logic [ROT_W-1:0]     rot_cnt_q;
    logic [ROT_W-1:0]     rot_cnt_d;
    logic                 run_q;
    logic                 run_d;
    logic                 start_batch;
    logic                 clr_lanes;

    logic [NUM_LANES-1:0] full_vec;
    logic [NUM_LANES-1:0] in_ready_vec;
    logic [NUM_LANES-1:0] out_valid_vec;
    logic [NUM_LANES-1:0] lane_load_vec;

    // Unreachable encoding: lanes are flushed while the FSM returns to FILL.
    assign clr_lanes = (state_q != FILL) && (state_q != ROTATE) && (state_q != DRAIN);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            carousel_lane_slot u_slot (
                .clk       (clk),
                .rst       (rst),
                .state     (state_q),
                .in_en     (run_q),
                .clr       (clr_lanes),
                .in_valid  (bus.data_in_valid[gi]),
                .out_ready (bus.data_out_ready[gi]),
                .in_ready  (in_ready_vec[gi]),
                .out_valid (out_valid_vec[gi]),
                .lane_load (lane_load_vec[gi]),
                .full      (full_vec[gi])
            );
        end
    endgenerate

    assign bus.data_in_ready  = in_ready_vec;
    assign bus.data_out_valid = out_valid_vec;
    assign bus.lane_load      = lane_load_vec;
    assign bus.rotate_en      = (state_q == ROTATE);
    assign busy               = (state_q == ROTATE) || (state_q == DRAIN);
    assign state_o            = state_q;

    // A batch starts once the registered full vector is complete (or on flush
    // with at least one lane occupied, when that feature is built in).
`ifdef CAROUSEL_SCHED_FLUSH_EN
    assign start_batch = (&full_vec) || (flush && (|full_vec));
`else
    assign start_batch = &full_vec;
`endif

    // Next-state and rotation-counter logic.
    always_comb begin
        state_d   = state_q;
        rot_cnt_d = rot_cnt_q;
        run_d     = 1'b1;
        case (state_q)
            FILL: begin
                if (start_batch) begin
                    rot_cnt_d = cfg_rotations;
                    state_d   = (cfg_rotations != '0) ? ROTATE : DRAIN;
                end
            end
            ROTATE: begin
                rot_cnt_d = rot_cnt_q - ROT_W'(1);
                if (rot_cnt_q <= ROT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!(|full_vec)) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d   = FILL;
                rot_cnt_d = '0;
            end
        endcase
    end

    // FSM state, rotation counter and post-reset run flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            rot_cnt_q <= '0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rot_cnt_q <= rot_cnt_d;
            run_q     <= run_d;
        end
    end

endmodule

// File: tb/tb_carousel_scheduler.sv
// tb_carousel_scheduler: directed checks of the carousel scheduler (N=3, ROT_W=4).
// Build with CAROUSEL_SCHED_FLUSH_EN defined to also exercise the flush path.
module tb_carousel_scheduler;
    import carousel_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] cfg_rotations;
    logic       flush;
    logic       busy;
    logic [1:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rot;

    carousel_scheduler_if #(.NUM_LANES(3)) bus_if ();

    carousel_scheduler #(
        .NUM_LANES (3),
        .ROT_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_rotations (cfg_rotations),
`ifdef CAROUSEL_SCHED_FLUSH_EN
        .flush         (flush),
`endif
        .bus           (bus_if.master),
        .busy          (busy),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                   = 1'b0;
        cfg_rotations         = 4'd0;
        flush                 = 1'b0;
        bus_if.data_in_valid  = 3'b111;   // offered during reset, must not load
        bus_if.data_out_ready = 3'b000;
        #1;
        chk("reset_ready",     32'(bus_if.data_in_ready),  32'h0);
        chk("reset_load",      32'(bus_if.lane_load),      32'h0);
        chk("reset_out_valid", 32'(bus_if.data_out_valid), 32'h0);
        chk("reset_rotate",    32'(bus_if.rotate_en),      32'h0);
        chk("reset_busy",      32'(busy),                  32'h0);
        chk("reset_state",     32'(state_o),               32'h0);
        cyc();
        cyc();
        chk("reset_hold_ready", 32'(bus_if.data_in_ready), 32'h0);
        bus_if.data_in_valid = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("release_ready", 32'(bus_if.data_in_ready), 32'h7);
        chk("release_state", 32'(state_o),               32'h0);

        // Concurrent fill, two rotations.
        cfg_rotations        = 4'd2;
        bus_if.data_in_valid = 3'b111;
        #1;
        chk("conc_load", 32'(bus_if.lane_load), 32'h7);
        cyc();
        bus_if.data_in_valid = 3'b000;
        #1;
        chk("conc_trans_ready", 32'(bus_if.data_in_ready), 32'h0);
        chk("conc_trans_state", 32'(state_o),              32'h0);
        chk("conc_trans_rot",   32'(bus_if.rotate_en),     32'h0);
        cyc();
        chk("conc_rot1_en",    32'(bus_if.rotate_en), 32'h1);
        chk("conc_rot1_state", 32'(state_o),          32'h1);
        chk("conc_rot1_busy",  32'(busy),             32'h1);
        cyc();
        chk("conc_rot2_en", 32'(bus_if.rotate_en), 32'h1);
        cyc();
        chk("conc_drain_rot",   32'(bus_if.rotate_en),      32'h0);
        chk("conc_drain_state", 32'(state_o),               32'h2);
        chk("conc_drain_valid", 32'(bus_if.data_out_valid), 32'h7);
        chk("conc_drain_ready", 32'(bus_if.data_in_ready),  32'h0);

        // Drain back-pressure.
        bus_if.data_out_ready = 3'b001;
        cyc();
        chk("bp_valid_a", 32'(bus_if.data_out_valid), 32'h6);
        bus_if.data_out_ready = 3'b100;
        cyc();
        chk("bp_valid_b", 32'(bus_if.data_out_valid), 32'h2);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("bp_valid_hold", 32'(bus_if.data_out_valid), 32'h2);
        end
        bus_if.data_out_ready = 3'b010;
        cyc();
        chk("bp_valid_c",     32'(bus_if.data_out_valid), 32'h0);
        chk("bp_empty_state", 32'(state_o),               32'h2);
        bus_if.data_out_ready = 3'b000;
        cyc();
        chk("bp_fill_state", 32'(state_o),              32'h0);
        chk("bp_fill_ready", 32'(bus_if.data_in_ready), 32'h7);

        // Staggered fill, zero rotations.
        cfg_rotations        = 4'd0;
        bus_if.data_in_valid = 3'b001;
        #1;
        chk("stag_load0", 32'(bus_if.lane_load), 32'h1);
        cyc();
        bus_if.data_in_valid = 3'b000;
        #1;
        chk("stag_ready_after0", 32'(bus_if.data_in_ready), 32'h6);
        cyc();
        cyc();
        bus_if.data_in_valid = 3'b010;
        cyc();
        bus_if.data_in_valid = 3'b000;
        cyc();
        bus_if.data_in_valid = 3'b100;
        #1;
        chk("stag_load2", 32'(bus_if.lane_load), 32'h4);
        cyc();
        bus_if.data_in_valid = 3'b000;
        #1;
        chk("stag_trans_state", 32'(state_o),              32'h0);
        chk("stag_trans_ready", 32'(bus_if.data_in_ready), 32'h0);
        chk("stag_trans_rot",   32'(bus_if.rotate_en),     32'h0);
        cyc();
        chk("stag_drain_state", 32'(state_o),               32'h2);
        chk("stag_drain_valid", 32'(bus_if.data_out_valid), 32'h7);
        chk("stag_drain_rot",   32'(bus_if.rotate_en),      32'h0);

        // Reset held mid-DRAIN.
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_drain_valid", 32'(bus_if.data_out_valid), 32'h0);
        chk("rst_drain_state", 32'(state_o),               32'h0);
        chk("rst_drain_busy",  32'(busy),                  32'h0);
        chk("rst_drain_ready", 32'(bus_if.data_in_ready),  32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_hold_ready", 32'(bus_if.data_in_ready), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("rst_rel_ready", 32'(bus_if.data_in_ready), 32'h7);
        chk("rst_rel_state", 32'(state_o),              32'h0);

        // Maximum rotation count; cfg change during ROTATE is ignored.
        cfg_rotations        = 4'hF;
        bus_if.data_in_valid = 3'b111;
        cyc();
        bus_if.data_in_valid = 3'b000;
        cyc();
        chk("max_rot_state", 32'(state_o), 32'h1);
        cfg_rotations = 4'h1;
        n_rot = 0;
        for (int k = 0; k < 40 && state_o != 2'b10; k++) begin
            if (bus_if.rotate_en) n_rot++;
            cyc();
        end
        chk("max_rot_count", 32'(n_rot),   32'd15);
        chk("max_rot_drain", 32'(state_o), 32'h2);
        bus_if.data_out_ready = 3'b111;
        cyc();
        bus_if.data_out_ready = 3'b000;
        cyc();
        chk("max_rot_refill", 32'(state_o), 32'h0);

`ifdef CAROUSEL_SCHED_FLUSH_EN
        // Flush a partially filled carousel.
        cfg_rotations        = 4'd1;
        bus_if.data_in_valid = 3'b010;
        cyc();
        bus_if.data_in_valid = 3'b000;
        flush                = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_rot_state", 32'(state_o),          32'h1);
        chk("flush_rot_en",    32'(bus_if.rotate_en), 32'h1);
        cyc();
        chk("flush_drain_state", 32'(state_o),               32'h2);
        chk("flush_drain_valid", 32'(bus_if.data_out_valid), 32'h2);
        bus_if.data_out_ready = 3'b010;
        cyc();
        bus_if.data_out_ready = 3'b000;
        chk("flush_drained", 32'(bus_if.data_out_valid), 32'h0);
        cyc();
        chk("flush_fill_state", 32'(state_o),              32'h0);
        chk("flush_fill_ready", 32'(bus_if.data_in_ready), 32'h7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/carousel_scheduler.md
Name: carousel_scheduler

Overview:
- Control-only sequencer for an N-lane rotating register buffer (carousel).
- Owns per-lane occupancy, all valid/ready handshakes and the rotate strobe; the external datapath holds the registers and obeys lane_load and rotate_en.
- Runs a fixed batch cycle: fill every lane, rotate a configurable number of steps, drain every lane, repeat.
- Sits between upstream producers and downstream consumers of the carousel datapath.

Parameters:
- NUM_LANES, 3, number of carousel lanes (>=2).
- ROT_W, 4, width of the rotation-count configuration.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- cfg_rotations  in  ROT_W  rotation steps per batch; sampled on FILL->ROTATE.
- data_in_valid  in  NUM_LANES  per-lane upstream valid.
- data_in_ready  out  NUM_LANES  per-lane upstream ready.
- data_out_valid  out  NUM_LANES  per-lane downstream valid.
- data_out_ready  in  NUM_LANES  per-lane downstream ready.
- lane_load  out  NUM_LANES  datapath load enable: register i captures data_in_i this edge.
- rotate_en  out  1  datapath rotate strobe: reg[i] <= reg[(i+1) mod N] this edge.
- busy  out  1  high in ROTATE or DRAIN.
- state_o  out  2  current FSM state encoding (debug).

Behaviour:
- Reset (rst=0, async): state=FILL, full=0, rot_cnt=0.
  - Outputs during reset: data_in_ready=0, data_out_valid=0, lane_load=0, rotate_en=0, busy=0.
  - data_in_ready rises on the first clock edge after release.
  - Reset mid-ROTATE/DRAIN discards the batch; the datapath contents become don't-care.
- State FILL (00):
  - data_in_ready[i] = ~full[i] (combinational from registered full).
  - lane_load[i] = data_in_valid[i] & data_in_ready[i]; that edge sets full[i].
  - Lanes fill independently and in any order; a filled lane does not accept again.
  - data_out_valid=0.
  - When every lane is full (registered): latch rot_cnt=cfg_rotations; next state is ROTATE if cfg_rotations!=0, else DRAIN.
  - The check uses the registered full vector, so the transition happens the cycle after the last load. data_in_ready is all-zero in that cycle.
- State ROTATE (01):
  - rotate_en=1 every cycle; rot_cnt decrements each cycle.
  - When rot_cnt==1, that cycle is the final rotate; next state is DRAIN.
  - Exactly cfg_rotations consecutive rotate_en cycles, no bubbles.
  - All in-ready and out-valid signals are 0. cfg_rotations changes during ROTATE are ignored.
- State DRAIN (10):
  - data_out_valid[i] = full[i]; an out handshake clears full[i]. Lanes drain independently, in any order.
  - data_in_ready=0; lane_load=0; rotate_en=0.
  - When all full bits are clear (registered): next state is FILL, with data_in_ready high that same cycle.
- Handshake rules:
  - Valid and ready never depend combinationally on the partner's same-direction signal.
  - data_out_valid never drops without a handshake.
- Encoding 11 is unreachable; if entered, recover to FILL with full cleared.
- Latency for N=3, R rotations, no back-pressure: 3 loads (1 cycle if concurrent), +1 transition cycle, +R rotate cycles, then out valid.
- Width rules: rot_cnt is ROT_W bits, so the maximum is 2^ROT_W-1 rotations. Rotating N times is functionally identity but still issues N strobes.

Optional Feature:
- Macro: CAROUSEL_SCHED_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - In FILL, flush=1 with at least one full lane forces the ROTATE/DRAIN transition next edge, using the same cfg rule. Loads accepted that edge still count.
  - Empty lanes in DRAIN have data_out_valid=0 and are treated as already drained.
  - flush is ignored in ROTATE/DRAIN.
- Undefined: no flush port; only a complete fill starts a batch.

Decomposition:
- Package carousel_pkg: typedef enum logic [1:0] {FILL=2'b00, ROTATE=2'b01, DRAIN=2'b10} carousel_state_t; localparam CAROUSEL_STATE_W=2.
- Natural sub-module: carousel_lane_slot (one per lane, generate loop). It holds full[i] and produces in_ready/out_valid/lane_load from state and handshakes.
- The FSM and rotation counter stay in carousel_scheduler.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-DRAIN, then release -> outputs 0 while low; next edge state=FILL, data_in_ready=3'b111, full cleared.
- Concurrent fill, cfg_rotations=2: data_in_valid=3'b111 for one cycle -> lane_load=3'b111 once; next cycle ready=0; then rotate_en high exactly 2 cycles; then data_out_valid=3'b111.
- Staggered fill, cfg_rotations=0: lanes valid at cycles 1, 4, 6 -> ROTATE skipped, rotate_en never 1; DRAIN with out_valid=3'b111 two edges after the lane-2 load.
- Drain back-pressure: data_out_ready=3'b001, then 3'b100 for 5 cycles, then 3'b010 -> out_valid goes 111 -> 110 -> 010 -> 000; FILL entered with ready=111 the cycle after the last handshake.
- Max rotation: cfg_rotations=4'hF, changed to 4'h1 during ROTATE -> exactly 15 rotate_en cycles.
- With CAROUSEL_SCHED_FLUSH_EN: lane 1 only full, flush=1, cfg=1 -> one rotate; DRAIN with data_out_valid=3'b010; FILL after one handshake.
